pingpong_dp_buf: RTL and testbench

- Parametrised double-buffered (ping-pong) simple dual-port buffer. Successor to the single-bank simple dual-port RAM wrapper.
- Holds two banks of DEPTH x DATA_BITWIDTH. A producer fills one bank while a consumer drains the other.
- Bank ownership is tracked by hardware through done/ready handshakes.
- Adds byte write masks, a registered read-valid and sticky error flags. Used as the next-generation global-buffer slice between DRAM loader and PE-array feeders.

---
 rtl/pingpong_dp_buf.sv | 132 +++++++++++++
 tb/tb_pingpong_dp_buf.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/pingpong_dp_buf.sv
// Double-buffered simple dual-port buffer: the producer fills one bank while the consumer drains the other.
// Define PINGPONG_OUT_REG_EN to add a second read output register (read latency 2).
module pingpong_dp_buf #(
  parameter int DATA_BITWIDTH = 512,
  parameter int ADDR_BITWIDTH = 5,
  parameter int DEPTH         = 32,
  parameter int MASK_BITWIDTH = DATA_BITWIDTH / 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [ADDR_BITWIDTH-1:0] wr_addr,
  input  logic [DATA_BITWIDTH-1:0] wr_data,
  input  logic [MASK_BITWIDTH-1:0] wr_mask,
  input  logic                     wr_done,
  output logic                     wr_ready,
  input  logic                     rd_en,
  input  logic [ADDR_BITWIDTH-1:0] rd_addr,
  input  logic                     rd_done,
  output logic                     rd_ready,
  output logic [DATA_BITWIDTH-1:0] rd_data,
  output logic                     rd_valid,
  output logic                     wr_sel,
  output logic                     rd_sel,
  output logic [1:0]               bank_full,
  output logic [1:0]               err,
  input  logic                     err_clr
);

  localparam logic [ADDR_BITWIDTH:0] DEPTH_L = (ADDR_BITWIDTH + 1)'(DEPTH);

  logic [DATA_BITWIDTH-1:0] mem [2][DEPTH];

  logic       wr_in_range, rd_in_range;
  logic       wr_fire, wr_swap, wr_err;
  logic       rd_fire, rd_swap, rd_err;
  logic       wr_sel_nxt, rd_sel_nxt;
  logic [1:0] bank_full_nxt, err_nxt;

  assign wr_in_range = ({1'b0, wr_addr} < DEPTH_L);
  assign rd_in_range = ({1'b0, rd_addr} < DEPTH_L);

  // Bank ownership: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_sel    <= 1'b0;
      rd_sel    <= 1'b0;
      bank_full <= 2'b00;
      err       <= 2'b00;
    end else begin
      wr_sel    <= wr_sel_nxt;
      rd_sel    <= rd_sel_nxt;
      bank_full <= bank_full_nxt;
      err       <= err_nxt;
    end
  end

  // Bank ownership: next state. A ready writer and a ready reader always own different banks.
  always_comb begin
    wr_sel_nxt    = wr_sel;
    rd_sel_nxt    = rd_sel;
    bank_full_nxt = bank_full;
    err_nxt       = err_clr ? 2'b00 : err;
    if (wr_swap) begin
      bank_full_nxt[wr_sel] = 1'b1;
      wr_sel_nxt            = ~wr_sel;
    end
    if (rd_swap) begin
      bank_full_nxt[rd_sel] = 1'b0;
      rd_sel_nxt            = ~rd_sel;
    end
    err_nxt = err_nxt | {rd_err, wr_err};
  end

  // Bank ownership: outputs and datapath strobes
  always_comb begin
    wr_ready = ~bank_full[wr_sel];
    rd_ready = bank_full[rd_sel];
    wr_fire  = wr_en & wr_ready & wr_in_range;
    wr_swap  = wr_done & wr_ready;
    wr_err   = (wr_en | wr_done) & ~wr_ready;
    rd_fire  = rd_en & rd_ready;
    rd_swap  = rd_done & rd_ready;
    rd_err   = (rd_en | rd_done) & ~rd_ready;
  end

  // Byte-masked write into the producer's bank; storage is never reset
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      for (int i = 0; i < MASK_BITWIDTH; i++) begin
        if (wr_mask[i]) mem[wr_sel][wr_addr][i*8 +: 8] <= wr_data[i*8 +: 8];
      end
    end
  end

  logic [DATA_BITWIDTH-1:0] rd_data_p0;
  logic                     vld_p0;

  // Read stage p0: memory read, out-of-range addresses return zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_p0 <= '0;
      vld_p0     <= 1'b0;
    end else begin
      vld_p0 <= rd_fire;
      if (rd_fire) rd_data_p0 <= rd_in_range ? mem[rd_sel][rd_addr] : '0;
    end
  end

`ifdef PINGPONG_OUT_REG_EN
  logic [DATA_BITWIDTH-1:0] rd_data_p1;
  logic                     vld_p1;

  // Read stage p1: extra output register, data held while no new word arrives
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_p1 <= '0;
      vld_p1     <= 1'b0;
    end else begin
      vld_p1 <= vld_p0;
      if (vld_p0) rd_data_p1 <= rd_data_p0;
    end
  end

  assign rd_data  = rd_data_p1;
  assign rd_valid = vld_p1;
`else
  assign rd_data  = rd_data_p0;
  assign rd_valid = vld_p0;
`endif

endmodule

// File: tb/tb_pingpong_dp_buf.sv
// Directed bench for pingpong_dp_buf with a read-data scoreboard keyed on expected arrival cycle.
module tb_pingpong_dp_buf;

`ifdef PINGPONG_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         wr_en, wr_done, rd_en, rd_done, err_clr;
  logic [4:0]   wr_addr, rd_addr;
  logic [511:0] wr_data;
  logic [63:0]  wr_mask;
  logic         wr_ready, rd_ready, rd_valid, wr_sel, rd_sel;
  logic [511:0] rd_data;
  logic [1:0]   bank_full, err;

  logic [511:0] model [2][32];
  logic [511:0] exp_q [$];
  int           due_q [$];
  int           cyc = 0;
  int           nasserts = 0;
  int           nfail = 0;

  pingpong_dp_buf dut (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_mask(wr_mask),
    .wr_done(wr_done), .wr_ready(wr_ready),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_done(rd_done), .rd_ready(rd_ready),
    .rd_data(rd_data), .rd_valid(rd_valid),
    .wr_sel(wr_sel), .rd_sel(rd_sel), .bank_full(bank_full),
    .err(err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    nasserts++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic sb_check();
    logic [511:0] d;
    int           c;
    if (rd_valid) begin
      nasserts++;
      assert (exp_q.size() > 0) else begin
        nfail++;
        $error("FAIL unexpected_valid observed=1 expected=0 cycle=%0d", cyc);
      end
      if (exp_q.size() > 0) begin
        d = exp_q.pop_front();
        c = due_q.pop_front();
        chk("rd_latency", 512'(cyc), 512'(c));
        chk("rd_data", rd_data, d);
      end
    end else if (due_q.size() > 0 && due_q[0] <= cyc) begin
      chk("missing_valid", 512'(rd_valid), 512'd1);
      void'(exp_q.pop_front());
      void'(due_q.pop_front());
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    sb_check();
  endtask

  task automatic drain(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic wr(input int bank, input int addr, input logic [511:0] d,
                    input logic [63:0] m, input bit done, input bit accept);
    wr_en = 1'b1; wr_addr = addr[4:0]; wr_data = d; wr_mask = m; wr_done = done;
    if (accept)
      for (int i = 0; i < 64; i++)
        if (m[i]) model[bank][addr][i*8 +: 8] = d[i*8 +: 8];
    tick();
    wr_en = 1'b0; wr_done = 1'b0; wr_mask = '0;
  endtask

  task automatic rd(input int bank, input int addr, input bit done);
    rd_en = 1'b1; rd_addr = addr[4:0]; rd_done = done;
    exp_q.push_back(model[bank][addr]);
    due_q.push_back(cyc + LAT);
    tick();
    rd_en = 1'b0; rd_done = 1'b0;
  endtask

  task automatic chk_state(input string tag, input logic [1:0] bf, input logic ws,
                           input logic rs, input logic wrdy, input logic rrdy);
    chk({tag, "_bank_full"}, 512'(bank_full), 512'(bf));
    chk({tag, "_wr_sel"}, 512'(wr_sel), 512'(ws));
    chk({tag, "_rd_sel"}, 512'(rd_sel), 512'(rs));
    chk({tag, "_wr_ready"}, 512'(wr_ready), 512'(wrdy));
    chk({tag, "_rd_ready"}, 512'(rd_ready), 512'(rrdy));
  endtask

  initial begin
    for (int b = 0; b < 2; b++)
      for (int a = 0; a < 32; a++) model[b][a] = '0;
    rst = 1'b1;
    wr_en = 0; wr_done = 0; rd_en = 0; rd_done = 0; err_clr = 0;
    wr_addr = '0; rd_addr = '0; wr_data = '0; wr_mask = '0;
    drain(2);
    rst = 1'b0;
    tick();

    // Reset then idle
    chk_state("reset", 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("reset_rd_valid", 512'(rd_valid), 512'd0);
    chk("reset_rd_data", rd_data, 512'd0);
    chk("reset_err", 512'(err), 512'd0);

    // Fill bank 0 with data=addr, wr_done on the last word
    for (int a = 0; a < 32; a++) wr(0, a, 512'(a), '1, (a == 31), 1'b1);
    chk_state("fill0", 2'b01, 1'b1, 1'b0, 1'b1, 1'b1);
    rd(0, 5, 1'b0);
    drain(3);

    // Fill bank 1 while bank 0 is still full
    for (int a = 0; a < 32; a++) wr(1, a, 512'(32'h100 + a), '1, (a == 31), 1'b1);
    chk_state("both_full", 2'b11, 1'b0, 1'b0, 1'b0, 1'b1);

    // Writes while not ready are dropped and flag err[0]; clear vs new error
    wr(1, 0, 512'hDEAD, '1, 1'b0, 1'b0);
    chk("err_wr_stall", 512'(err), 512'd1);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    chk("err_clr", 512'(err), 512'd0);
    err_clr = 1'b1;
    wr(1, 0, 512'hDEAD, '1, 1'b0, 1'b0);
    err_clr = 1'b0;
    chk("err_new_wins", 512'(err), 512'd1);
    wr(0, 1, 512'hDEAD, '1, 1'b1, 1'b0);
    chk_state("done_stall", 2'b11, 1'b0, 1'b0, 1'b0, 1'b1);
    err_clr = 1'b1; tick(); err_clr = 1'b0;

    // Drain bank 0 with rd_done on the final read
    rd(0, 0, 1'b0);
    rd(0, 31, 1'b1);
    chk_state("release0", 2'b10, 1'b0, 1'b1, 1'b1, 1'b1);
    drain(3);

    // Byte-masked writes onto existing words of bank 0
    wr(0, 0, {64{8'hFF}}, 64'h1, 1'b0, 1'b1);
    wr(0, 2, {64{8'hFF}}, 64'h8000_0000_0000_0000, 1'b0, 1'b1);

    // Read bank 1, then same-cycle write+wr_done on bank 0 and read+rd_done on bank 1
    rd(1, 31, 1'b0);
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 512'h55AA; wr_mask = '1; wr_done = 1'b1;
    model[0][5] = 512'h55AA;
    rd_en = 1'b1; rd_addr = 5'd0; rd_done = 1'b1;
    exp_q.push_back(model[1][0]);
    due_q.push_back(cyc + LAT);
    tick();
    wr_en = 0; wr_done = 0; wr_mask = '0; rd_en = 0; rd_done = 0;
    chk_state("swap", 2'b01, 1'b1, 1'b0, 1'b1, 1'b1);
    drain(3);

    // Read back the masked words and the same-cycle write, release bank 0
    rd(0, 0, 1'b0);
    rd(0, 5, 1'b0);
    rd(0, 2, 1'b1);
    drain(3);
    chk_state("all_empty", 2'b00, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("err_clean", 512'(err), 512'd0);

    // Reads and rd_done while not ready are dropped and flag err[1]
    rd_en = 1'b1; rd_addr = 5'd0; tick(); rd_en = 1'b0;
    chk("err_rd_stall", 512'(err), 512'd2);
    rd_done = 1'b1; tick(); rd_done = 1'b0;
    chk_state("rd_stall", 2'b00, 1'b1, 1'b1, 1'b1, 1'b0);
    drain(3);
    err_clr = 1'b1; tick(); err_clr = 1'b0;

    // Reset while a read is in flight
    wr(1, 3, 512'hABC, '1, 1'b1, 1'b1);
    chk("pre_rst_rd_ready", 512'(rd_ready), 512'd1);
    rd_en = 1'b1; rd_addr = 5'd3;
`ifdef PINGPONG_OUT_REG_EN
    tick();
    rd_en = 1'b0;
    chk("inflight_valid_low", 512'(rd_valid), 512'd0);
`endif
    #2 rst = 1'b1;
    rd_en = 1'b0;
    #1;
    chk("rst_async_valid", 512'(rd_valid), 512'd0);
    chk("rst_async_full", 512'(bank_full), 512'd0);
    drain(2);
    chk_state("rst_mid", 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("rst_mid_data", rd_data, 512'd0);
    rst = 1'b0;
    drain(3);
    chk("rst_mid_valid", 512'(rd_valid), 512'd0);

    // Normal operation resumes after reset
    wr(0, 7, 512'h77, '1, 1'b1, 1'b1);
    rd(0, 7, 1'b0);
    drain(3);
    chk("queue_empty", 512'(exp_q.size()), 512'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nasserts, nfail);
    $finish;
  end

endmodule
